spi_seq_ctrl: RTL and testbench
===============================

SPI_SEQ_CTRL -- requirements
Module: spi_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum POLL cycles before a transfer is aborted.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: base address of the SPI peripheral; CTRL=+0x0, TX=+0x4, STATUS=+0x8.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 a_valid_i / b_valid_i  in  1 each  requester A/B has a byte to send.
REQ-006 a_data_i / b_data_i  in  8 each  byte to transmit.
REQ-007 a_ready_o / b_ready_o  out  1 each  byte accepted this cycle (valid&ready = handshake).
REQ-008 a_done_o / b_done_o  out  1 each  one-cycle pulse: that requester's byte finished on SPI.
REQ-009 err_o  out  1  one-cycle pulse: transfer aborted by timeout.
REQ-010 obi_req_o  out  1  OBI request to peripheral.
REQ-011 obi_we_o  out  1  OBI write enable.
REQ-012 obi_addr_o  out  32  OBI address.
REQ-013 obi_wdata_o  out  32  OBI write data.
REQ-014 obi_gnt_i  in  1  OBI grant (may be combinational from obi_req_o).
REQ-015 obi_rvalid_i  in  1  OBI read valid (may be same cycle as grant).
REQ-016 obi_rdata_i  in  32  OBI read data; bit0=busy, bit1=done.

Function
REQ-017 FSM states: IDLE, WR_TX, WR_CTRL, POLL, FINISH.
REQ-018 IDLE: if any valid, arbiter selects one requester, asserts its ready for exactly one cycle, latches data and owner id, goes to WR_TX next cycle; other ready stays 0.
REQ-019 Arbitration: round-robin; if both valid, grant the requester not granted last; last-granted pointer resets to B so A wins first tie.
REQ-020 A single valid requester is granted regardless of pointer; pointer updates only on a grant.
REQ-021 ready outputs are 0 in every state except IDLE; at most one ready high per cycle.
REQ-022 WR_TX: obi_req_o=1, we=1, addr=BASE+0x4, wdata={24'h0,latched byte}; hold all until obi_gnt_i=1, then WR_CTRL.
REQ-023 WR_CTRL: obi_req_o=1, we=1, addr=BASE+0x0, wdata=32'h1; hold until obi_gnt_i=1, then POLL with timeout counter cleared.
REQ-024 POLL: obi_req_o=1, we=0, addr=BASE+0x8 asserted every cycle (continuous polling; done is a one-cycle pulse and must not be missed).
REQ-025 POLL exit: cycle with obi_rvalid_i=1 and obi_rdata_i[1]=1 -> FINISH.
REQ-026 POLL timeout: counter increments each POLL cycle not exiting; on reaching TIMEOUT_CYCLES -> FINISH flagged as error.
REQ-027 FINISH (one cycle): obi_req_o=0; pulse owner's done_o if no error, else pulse err_o (no done); then IDLE.
REQ-028 Minimum IDLE-to-IDLE with zero-wait grants: 1 (IDLE) + 1 (WR_TX) + 1 (WR_CTRL) + N poll + 1 (FINISH) cycles; a new grant is possible in the cycle after FINISH.
REQ-029 Outside WR_TX/WR_CTRL/POLL: obi_req_o=0, obi_we_o=0, obi_addr_o=0, obi_wdata_o=0.
REQ-030 Requester data changes after handshake have no effect on the transfer in flight.
REQ-031 Timeout counter width = $clog2(TIMEOUT_CYCLES+1); no wrap possible.
REQ-032 rdata bit1 seen while not in POLL is ignored.

Reset
REQ-033 rst_i high at a clock edge: state=IDLE, rr pointer=B, counter=0, latched byte=0; all outputs 0 (ready, done, err, obi_*) in the following cycle.
REQ-034 Reset mid-transfer aborts silently: no done/err pulse, obi_req_o drops the cycle after the reset edge.

Verification
REQ-035 A valid, data 0xA5, zero-wait gnt, done at 9th poll -> a_ready 1 cycle; writes TX=0x000000A5 then CTRL=0x1; 9 status reads; a_done_o pulse; total 13 cycles.
REQ-036 A and B valid continuously after reset -> grant order A,B,A,B; each done pulse matches owner.
REQ-037 gnt_i held low 5 cycles in WR_TX -> req/addr/wdata stable 6 cycles, no advance until gnt.
REQ-038 STATUS never reports done, TIMEOUT_CYCLES=64 -> exactly 64 POLL cycles, err_o pulse, no done, returns IDLE.
REQ-039 rst_i asserted during POLL -> next cycle all outputs 0, no done/err; subsequent A request completes normally.
REQ-040 Connected to the real SPI peripheral, byte 0x3C -> MOSI sequence 0,0,1,1,1,1,0,0 with cs low for 8 cycles, then a_done_o.

Source files
------------

// File: rtl/spi_seq_ctrl.sv
// Sequences one byte per transfer from two round-robin requesters onto an SPI peripheral over OBI:
// write TX, write CTRL start, then poll STATUS until done or timeout.
module spi_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_valid_i,
  input  logic [7:0]  a_data_i,
  output logic        a_ready_o,
  output logic        a_done_o,
  input  logic        b_valid_i,
  input  logic [7:0]  b_data_i,
  output logic        b_ready_o,
  output logic        b_done_o,
  output logic        err_o,
  output logic        obi_req_o,
  output logic        obi_we_o,
  output logic [31:0] obi_addr_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_gnt_i,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, WR_TX, WR_CTRL, POLL, FINISH} state_e;

  state_e           state_q, state_d;
  logic             last_b_q;
  logic             owner_b_q;
  logic             err_q;
  logic [7:0]       byte_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             grant_a, grant_b;
  logic             poll_done;
  logic             unused_rdata;

  assign unused_rdata = ^{obi_rdata_i[31:2], obi_rdata_i[0]};
  assign poll_done    = obi_rvalid_i & obi_rdata_i[1];
  assign cnt_next     = cnt_q + CNT_W'(1);

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      grant_a = a_valid_i & (~b_valid_i | last_b_q);
      grant_b = b_valid_i & (~a_valid_i | ~last_b_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
      err_q     <= 1'b0;
      byte_q    <= 8'h00;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_a || grant_b) begin
        byte_q    <= grant_a ? a_data_i : b_data_i;
        owner_b_q <= grant_b;
        last_b_q  <= grant_b;
        err_q     <= 1'b0;
      end
      if (state_q == WR_CTRL && obi_gnt_i) begin
        cnt_q <= '0;
      end
      if (state_q == POLL && !poll_done) begin
        cnt_q <= cnt_next;
        if (cnt_next == TIMEOUT_VAL) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    a_ready_o   = grant_a;
    b_ready_o   = grant_b;
    a_done_o    = 1'b0;
    b_done_o    = 1'b0;
    err_o       = 1'b0;
    obi_req_o   = 1'b0;
    obi_we_o    = 1'b0;
    obi_addr_o  = 32'h0;
    obi_wdata_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (grant_a || grant_b) state_d = WR_TX;
      end
      WR_TX: begin
        obi_req_o   = 1'b1;
        obi_we_o    = 1'b1;
        obi_addr_o  = BASE_ADDR + 32'h4;
        obi_wdata_o = {24'h0, byte_q};
        if (obi_gnt_i) state_d = WR_CTRL;
      end
      WR_CTRL: begin
        obi_req_o   = 1'b1;
        obi_we_o    = 1'b1;
        obi_addr_o  = BASE_ADDR;
        obi_wdata_o = 32'h1;
        if (obi_gnt_i) state_d = POLL;
      end
      POLL: begin
        // Request every cycle so a one-cycle done indication is never missed.
        obi_req_o  = 1'b1;
        obi_addr_o = BASE_ADDR + 32'h8;
        if (poll_done || cnt_next == TIMEOUT_VAL) state_d = FINISH;
      end
      FINISH: begin
        a_done_o = ~err_q & ~owner_b_q;
        b_done_o = ~err_q & owner_b_q;
        err_o    = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// Randomized transaction-level bench for spi_seq_ctrl with a behavioural OBI peripheral model
// and a round-robin / timeout reference computed per transfer.
module tb_spi_seq_ctrl;

  localparam int unsigned TIMEOUT = 64;
  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0]  a_data = 8'h00, b_data = 8'h00;
  logic        a_ready, b_ready, a_done, b_done, err;
  logic        obi_req, obi_we, obi_gnt, obi_rvalid;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic        gnt_en = 1'b0;
  logic        done_flag = 1'b0;

  int tests_run = 0;
  int failures = 0;
  bit last_b = 1'b1;

  always #5 clk = ~clk;

  // Peripheral: grant when enabled, respond the same cycle; writes return junk with bit1 set.
  assign obi_gnt    = obi_req & gnt_en;
  assign obi_rvalid = obi_gnt;
  assign obi_rdata  = obi_we ? 32'h0000_0003 : {30'h0, done_flag, 1'b1};

  spi_seq_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready), .a_done_o(a_done),
    .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready), .b_done_o(b_done),
    .err_o(err),
    .obi_req_o(obi_req), .obi_we_o(obi_we), .obi_addr_o(obi_addr), .obi_wdata_o(obi_wdata),
    .obi_gnt_i(obi_gnt), .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " outputs"},
                {a_ready, b_ready, a_done, b_done, err, obi_req, obi_we},
                32'h0);
    checkOutput({tag, " addr"}, obi_addr, 32'h0);
    checkOutput({tag, " wdata"}, obi_wdata, 32'h0);
  endtask

  task automatic checkWrite(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    checkOutput({tag, " req/we/ready"}, {obi_req, obi_we, a_ready, b_ready}, 32'hC);
    checkOutput({tag, " addr"}, obi_addr, addr);
    checkOutput({tag, " wdata"}, obi_wdata, wdata);
  endtask

  // One full transfer. doneAt=0 means STATUS never reports done; resetAtPoll>0 resets mid-poll.
  task automatic applyStimulus(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd,
                               input int doneAt, input int txWait, input int ctrlWait,
                               input int resetAtPoll);
    bit ownerB;
    bit timeout;
    logic [7:0] expByte;
    int polls;
    ownerB  = (av && bv) ? !last_b : bv;
    expByte = ownerB ? bd : ad;
    timeout = (doneAt == 0) || (doneAt > int'(TIMEOUT));
    polls   = timeout ? int'(TIMEOUT) : doneAt;

    @(negedge clk);
    a_valid = av; b_valid = bv; a_data = ad; b_data = bd;
    gnt_en = 1'b0; done_flag = 1'b0;
    #1;
    checkOutput("idle ready", {a_ready, b_ready}, {!ownerB, ownerB});
    checkOutput("idle quiet", {a_done, b_done, err, obi_req}, 32'h0);
    last_b = ownerB;

    for (int w = 0; w <= txWait; w++) begin
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      a_data = 8'($urandom); b_data = 8'($urandom);
      gnt_en = (w == txWait);
      #1;
      checkWrite("wr_tx", BASE + 32'h4, {24'h0, expByte});
    end
    for (int w = 0; w <= ctrlWait; w++) begin
      @(negedge clk);
      gnt_en = (w == ctrlWait);
      #1;
      checkWrite("wr_ctrl", BASE, 32'h1);
    end
    for (int k = 1; k <= polls; k++) begin
      @(negedge clk);
      gnt_en = 1'b1;
      done_flag = (k == doneAt);
      rst = (k == resetAtPoll);
      #1;
      checkOutput("poll req/we", {obi_req, obi_we, a_ready, b_ready, a_done, b_done, err}, 32'h40);
      checkOutput("poll addr", obi_addr, BASE + 32'h8);
      if (k == resetAtPoll) begin
        @(negedge clk);
        rst = 1'b0; done_flag = 1'b0; gnt_en = 1'b0;
        #1;
        checkQuiet("after reset");
        last_b = 1'b1;
        return;
      end
    end
    @(negedge clk);
    gnt_en = 1'b0; done_flag = 1'b0;
    #1;
    checkOutput("finish req", obi_req, 32'h0);
    checkOutput("finish pulses", {a_done, b_done, err},
                {!timeout && !ownerB, !timeout && ownerB, timeout});
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; gnt_en = 1'b0; done_flag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkQuiet("reset");
    last_b = 1'b1;
  endtask

  initial begin
    int dn;
    bit av, bv;
    repeat (3) @(negedge clk);
    doReset();

    // Single A transfer with zero-wait grants and done on the 9th poll.
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00, 9, 0, 0, 0);

    // Continuous contention right after reset alternates A, B, A, B.
    doReset();
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 3, 0, 0, 0);
    applyStimulus(1'b1, 8'h33, 1'b1, 8'h44, 1, 0, 0, 0);
    applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 2, 0, 0, 0);
    applyStimulus(1'b1, 8'h77, 1'b1, 8'h88, 5, 0, 0, 0);

    // Grant stalled 5 cycles on the TX write, then 2 on CTRL.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h5A, 4, 5, 2, 0);

    // Peripheral never finishes, then finishes exactly on the last allowed poll.
    applyStimulus(1'b1, 8'hC3, 1'b0, 8'h00, 0, 0, 0, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C, int'(TIMEOUT), 0, 0, 0);

    // Reset while polling, then a normal A transfer.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h99, 7, 0, 0, 3);
    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00, 2, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      av = 1'($urandom);
      bv = av ? 1'($urandom) : 1'b1;
      dn = $urandom_range(0, 70);
      applyStimulus(av, 8'($urandom), bv, 8'($urandom), dn,
                    $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    @(negedge clk);
    #1;
    checkQuiet("final idle");
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
